avalon_bus_arbiter: RTL and testbench

// - Shares the single Avalon-MM slave port of the UART core between two requesters
//   (req 0 = IRQ-driven RX drain, req 1 = TX/config writer).
// - Round-robin grant, one transaction at a time, honours waitrequest_in.
// - Returns read data plus done/error pulses; a timeout aborts transfers stuck on waitrequest.

---
 rtl/avalon_arb_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 20 ++
 rtl/avalon_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_avalon_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_arb_pkg.sv
// rtl/avalon_arb_pkg.sv - shared types and widths for the UART Avalon-MM bus arbiter
package avalon_arb_pkg;

  localparam int NUM_REQ       = 2;
  localparam int AV_DATA_WIDTH = 32;
  localparam int AV_ADDR_WIDTH = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  typedef struct packed {
    logic                     write;
    logic [AV_ADDR_WIDTH-1:0] address;
    logic [AV_DATA_WIDTH-1:0] writedata;
  } av_cmd_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin winner select
module rr_pick2
  import avalon_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_grant,
  output logic               win
);

  // On contention the requester that did not own the last transfer wins.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = ~last_grant;
    end else begin
      win = req[1];
    end
  end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// rtl/avalon_bus_arbiter.sv - round-robin sharing of one Avalon-MM slave port between two requesters
module avalon_bus_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = AV_DATA_WIDTH,
  parameter int ADDR_WIDTH     = AV_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clock_in,
  input  logic                             reset_n_in,
  input  logic [NUM_REQ-1:0]               req_in,
  input  logic [NUM_REQ-1:0]               write_in,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] address_in,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] writedata_in,
  output logic [NUM_REQ-1:0]               grant_out,
  output logic [NUM_REQ-1:0]               done_out,
  output logic [NUM_REQ-1:0]               error_out,
  output logic [DATA_WIDTH-1:0]            readdata_out,
  output logic                             busy_out,
  output logic                             chipselect_out,
  output logic [ADDR_WIDTH-1:0]            address_out,
  output logic                             read_n_out,
  output logic                             write_n_out,
  output logic [DATA_WIDTH-1:0]            writedata_out,
  input  logic [DATA_WIDTH-1:0]            readdata_in,
  input  logic                             waitrequest_in
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t    state, state_next;
  logic          last_grant;
  logic          win;
  logic          tmo_hit;
  logic [TW-1:0] tmo_cnt;
  av_cmd_t       win_cmd;

  rr_pick2 u_pick (
    .req        (req_in),
    .last_grant (last_grant),
    .win        (win)
  );

  always_comb begin
    win_cmd           = '0;
    win_cmd.write     = write_in[win];
    win_cmd.address   = address_in[win];
    win_cmd.writedata = writedata_in[win];
  end

  // Fires on the ACCESS cycle that would bring the stall count up to TIMEOUT_CYCLES.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_in != '0) state_next = ACCESS;
      ACCESS:  if (!waitrequest_in || tmo_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      grant_out      <= '0;
      done_out       <= '0;
      error_out      <= '0;
      readdata_out   <= '0;
      busy_out       <= 1'b0;
      chipselect_out <= 1'b0;
      address_out    <= '0;
      read_n_out     <= 1'b1;
      write_n_out    <= 1'b1;
      writedata_out  <= '0;
      last_grant     <= 1'b1;
      tmo_cnt        <= '0;
    end else begin
      done_out  <= '0;
      error_out <= '0;
      busy_out  <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (req_in != '0) begin
            grant_out      <= win ? 2'b10 : 2'b01;
            chipselect_out <= 1'b1;
            read_n_out     <= win_cmd.write;
            write_n_out    <= ~win_cmd.write;
            address_out    <= win_cmd.address;
            writedata_out  <= win_cmd.writedata;
            tmo_cnt        <= '0;
          end
        end
        ACCESS: begin
          if (!waitrequest_in) begin
            if (!read_n_out) readdata_out <= readdata_in;
            chipselect_out <= 1'b0;
            read_n_out     <= 1'b1;
            write_n_out    <= 1'b1;
            done_out       <= grant_out;
            last_grant     <= grant_out[1];
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) begin
              chipselect_out <= 1'b0;
              read_n_out     <= 1'b1;
              write_n_out    <= 1'b1;
              error_out      <= grant_out;
              last_grant     <= grant_out[1];
            end
          end
        end
        DONE: begin
          grant_out <= '0;
        end
        default: begin
          grant_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// tb/tb_avalon_bus_arbiter.sv - scoreboard bench for the Avalon bus arbiter
module tb_avalon_bus_arbiter;

  localparam int TMO = 8;

  typedef struct {
    int          owner;
    bit          err;
    bit          wr;
    bit          addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_rd;
    int          cs_cycles;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_in, write_in;
  logic [1:0][0:0]  address_in;
  logic [1:0][31:0] writedata_in;
  logic [1:0]       grant_out, done_out, error_out;
  logic [31:0]      readdata_out, writedata_out, readdata_in;
  logic             busy_out, chipselect_out, read_n_out, write_n_out, waitrequest_in;
  logic [0:0]       address_out;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   m_last;
  logic [31:0] m_rd;
  int   cs_cnt = 0;
  int   idle_cnt = 0;
  bit   seen = 0;
  bit   exact_gap = 0;

  avalon_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(1), .TIMEOUT_CYCLES(TMO)) dut (
    .clock_in       (clk),
    .reset_n_in     (rst_n),
    .req_in         (req_in),
    .write_in       (write_in),
    .address_in     (address_in),
    .writedata_in   (writedata_in),
    .grant_out      (grant_out),
    .done_out       (done_out),
    .error_out      (error_out),
    .readdata_out   (readdata_out),
    .busy_out       (busy_out),
    .chipselect_out (chipselect_out),
    .address_out    (address_out),
    .read_n_out     (read_n_out),
    .write_n_out    (write_n_out),
    .writedata_out  (writedata_out),
    .readdata_in    (readdata_in),
    .waitrequest_in (waitrequest_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int w);
    return (w != 0) ? 2'b10 : 2'b01;
  endfunction

  // Reference arbitration: on contention the other requester than last time; else the sole one.
  function automatic int pick(input logic [1:0] rq, input int last);
    if (rq == 2'b11) return (last == 0) ? 1 : 0;
    return rq[1] ? 1 : 0;
  endfunction

  task automatic predict(input logic [1:0] rq, input logic [1:0] wr, input logic [1:0] ad,
                         input logic [1:0][31:0] wd, input int waits, input logic [31:0] rdata);
    exp_t e;
    int   w;
    w           = pick(rq, m_last);
    e.owner     = w;
    e.err       = (waits >= TMO);
    e.wr        = wr[w];
    e.addr      = ad[w];
    e.wdata     = wd[w];
    e.rdata     = rdata;
    e.waits     = waits;
    e.cs_cycles = e.err ? TMO : waits + 1;
    if (!e.err && !e.wr) m_rd = rdata;
    e.exp_rd    = m_rd;
    m_last      = w;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] rq, input logic [1:0] wr, input logic [1:0] ad,
                       input logic [1:0][31:0] wd);
    req_in        = rq;
    write_in      = wr;
    address_in[0] = ad[0];
    address_in[1] = ad[1];
    writedata_in  = wd;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_out == 2'b00 && error_out == 2'b00 && n < 60);
    if (n >= 60) chk("done or error within budget", {done_out, error_out}, 4'hf);
  endtask

  task automatic issue(input logic [1:0] rq, input logic [1:0] wr, input logic [1:0] ad,
                       input logic [1:0][31:0] wd, input int waits, input logic [31:0] rdata);
    @(negedge clk);
    predict(rq, wr, ad, wd, waits, rdata);
    drive(rq, wr, ad, wd);
    wait_done();
    req_in       = 2'b00;
    write_in     = 2'($urandom);
    writedata_in = {$urandom, $urandom};
  endtask

  // Slave model plus monitor: answers the bus from the pending plan and checks every output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cs_cnt         = 0;
        idle_cnt       = 0;
        seen           = 0;
        waitrequest_in = 1'b0;
      end else begin
        if (chipselect_out) begin
          if (cs_cnt == 0 && seen) begin
            if (exact_gap) chk("back-to-back gap", idle_cnt, 2);
            else           chk("turnaround gap >= 2", idle_cnt >= 2, 1);
          end
          cs_cnt++;
          if (exp_q.size() == 0) begin
            chk("chipselect with nothing pending", chipselect_out, 0);
            waitrequest_in = 1'b0;
          end else begin
            chk("address_out", address_out, exp_q[0].addr);
            chk("writedata_out", writedata_out, exp_q[0].wdata);
            chk("read_n_out", read_n_out, exp_q[0].wr);
            chk("write_n_out", write_n_out, !exp_q[0].wr);
            chk("grant during access", grant_out, oh(exp_q[0].owner));
            chk("busy during access", busy_out, 1);
            waitrequest_in = (cs_cnt <= exp_q[0].waits);
            readdata_in    = waitrequest_in ? $urandom : exp_q[0].rdata;
          end
        end else begin
          idle_cnt++;
          waitrequest_in = 1'($urandom_range(0, 1));
          readdata_in    = $urandom;
        end
        if (done_out != 2'b00 || error_out != 2'b00) begin
          if (exp_q.size() == 0) begin
            chk("unexpected done/error", {done_out, error_out}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("done_out", done_out, e.err ? 2'b00 : oh(e.owner));
            chk("error_out", error_out, e.err ? oh(e.owner) : 2'b00);
            chk("grant at completion", grant_out, oh(e.owner));
            chk("readdata_out", readdata_out, e.exp_rd);
            chk("chipselect cycles", cs_cnt, e.cs_cycles);
            chk("bus released", {chipselect_out, read_n_out, write_n_out}, 3'b011);
            chk("busy in turnaround", busy_out, 1);
          end
          cs_cnt   = 0;
          idle_cnt = 1;
          seen     = 1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run exceeded its time limit (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0][31:0] wd;
    logic [1:0]       wr, ad, rq;
    int               waits;

    rst_n          = 1'b0;
    req_in         = 2'b00;
    write_in       = 2'b00;
    address_in     = '0;
    writedata_in   = '0;
    readdata_in    = '0;
    waitrequest_in = 1'b0;
    m_last         = 1;
    m_rd           = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset chipselect", chipselect_out, 0);
    chk("reset read_n/write_n", {read_n_out, write_n_out}, 2'b11);
    chk("reset grant/done/error", {grant_out, done_out, error_out}, 0);
    chk("reset busy", busy_out, 0);
    chk("reset readdata", readdata_out, 0);
    chk("reset address/writedata", {address_out, writedata_out}, 0);

    wd = '0;
    issue(2'b01, 2'b00, 2'b01, wd, 2, 32'h0003000A);
    wd[1] = 32'h00000041;
    issue(2'b10, 2'b10, 2'b00, wd, 0, 32'hDEADBEEF);

    @(negedge clk);
    wr = 2'($urandom);
    ad = 2'($urandom);
    wd = {$urandom, $urandom};
    for (int k = 0; k < 4; k++) predict(2'b11, wr, ad, wd, int'($urandom_range(0, 3)), $urandom);
    drive(2'b11, wr, ad, wd);
    for (int k = 0; k < 4; k++) begin
      wait_done();
      exact_gap = 1;
    end
    req_in    = 2'b00;
    exact_gap = 0;

    issue(2'b01, 2'b00, 2'b00, wd, 100, $urandom);
    issue(2'b11, 2'($urandom), 2'($urandom), {$urandom, $urandom}, 1, $urandom);

    for (int r = 0; r < 40; r++) begin
      rq    = 2'($urandom_range(1, 3));
      waits = ($urandom_range(0, 9) < 9) ? int'($urandom_range(0, 4)) : 20;
      issue(rq, 2'($urandom), 2'($urandom), {$urandom, $urandom}, waits, $urandom);
    end

    @(negedge clk);
    predict(2'b01, 2'b00, 2'b00, wd, 100, 32'h0);
    drive(2'b01, 2'b00, 2'b00, wd);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid-access reset chipselect", chipselect_out, 0);
    chk("mid-access reset read_n/write_n", {read_n_out, write_n_out}, 2'b11);
    chk("mid-access reset grant/busy", {grant_out, busy_out}, 0);
    exp_q.delete();
    m_last = 1;
    m_rd   = '0;
    req_in = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b11, 2'($urandom), 2'($urandom), {$urandom, $urandom}, 1, $urandom);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
